// File: rtl/rs_dec_pkg.sv
// Shared RS(544,514) decoder parameters and types for the error-application stage.
package rs_dec_pkg;

    localparam int unsigned W     = 10;
    localparam int unsigned POS_W = 10;
    localparam int unsigned N     = 544;
    localparam int unsigned T_MAX = 15;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    // Index of the final symbol and the error count at which the table is full.
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(T_MAX);

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [W-1:0]     y;
    } err_entry_t;

    typedef enum logic {
        COLLECT,
        APPLY
    } apply_state_e;

endpackage

// File: rtl/rs_err_apply_if.sv
// Error-beat, received-symbol and corrected-symbol streams of rs_err_apply.
interface rs_err_apply_if;
    import rs_dec_pkg::*;

    logic             err_vld_i;
    logic             err_rdy_o;
    logic [POS_W-1:0] err_pos_i;
    logic [W-1:0]     err_y_i;
    logic             err_den_zero_i;
    logic             err_done_i;
    logic [CNT_W-1:0] nerr_exp_i;
    logic             sym_vld_i;
    logic             sym_rdy_o;
    logic [W-1:0]     sym_i;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [W-1:0]     out_sym_o;
    logic             out_last_o;
    logic [CNT_W-1:0] nerr_o;
    logic             dec_fail_o;

    // Seen from the error-application stage.
    modport slave (
        input  err_vld_i, err_pos_i, err_y_i, err_den_zero_i, err_done_i, nerr_exp_i,
        input  sym_vld_i, sym_i, out_rdy_i,
        output err_rdy_o, sym_rdy_o, out_vld_o, out_sym_o, out_last_o, nerr_o, dec_fail_o
    );

    // Seen from the Forney stage, codeword buffer and downstream consumer.
    modport master (
        output err_vld_i, err_pos_i, err_y_i, err_den_zero_i, err_done_i, nerr_exp_i,
        output sym_vld_i, sym_i, out_rdy_i,
        input  err_rdy_o, sym_rdy_o, out_vld_o, out_sym_o, out_last_o, nerr_o, dec_fail_o
    );

endinterface

// File: rtl/rs_err_table.sv
// Error table: T_MAX {pos, y} entries with valid bits, a symbol-index match port and a
// duplicate-position check port. Duplicate comparators exist only with
// RS_ERR_APPLY_FAIL_CHECK_EN defined.
module rs_err_table
    import rs_dec_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_idx,
    input  err_entry_t       i_wr_entry,
    input  logic [POS_W-1:0] i_match_pos,
    output logic             o_hit,
    output logic [W-1:0]     o_match_y,
    input  logic [POS_W-1:0] i_chk_pos,
    output logic             o_dup
);

    err_entry_t       r_entry [T_MAX];
    logic [T_MAX-1:0] r_valid;

    // Table storage: clear drops all entries, a write fills one slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < T_MAX; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            if (i_clr) begin
                r_valid <= '0;
            end
            if (i_wr_en) begin
                for (int unsigned i = 0; i < T_MAX; i++) begin
                    if (i_wr_idx == CNT_W'(i)) begin
                        r_entry[i] <= i_wr_entry;
                        r_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Match port: XOR of every valid entry at this index (a single one in normal use).
    always_comb begin
        o_hit     = 1'b0;
        o_match_y = '0;
        for (int unsigned i = 0; i < T_MAX; i++) begin
            if (r_valid[i] && (r_entry[i].pos == i_match_pos)) begin
                o_hit     = 1'b1;
                o_match_y = o_match_y ^ r_entry[i].y;
            end
        end
    end

`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    // Duplicate port: incoming position already present in the table.
    always_comb begin
        o_dup = 1'b0;
        for (int unsigned i = 0; i < T_MAX; i++) begin
            if (r_valid[i] && (r_entry[i].pos == i_chk_pos)) begin
                o_dup = 1'b1;
            end
        end
    end
`else
    logic w_unused_chk;
    assign w_unused_chk = ^i_chk_pos;
    assign o_dup        = 1'b0;
`endif

endmodule

// File: rtl/rs_err_apply.sv
// Error-application stage: collects the Forney error list for one codeword, then streams
// the received symbols through, XORing each stored magnitude onto its symbol index.
// Optional feature macro: RS_ERR_APPLY_FAIL_CHECK_EN (decode-failure detection; when set a
// failing codeword passes uncorrected and dec_fail_o reports it).
module rs_err_apply
    import rs_dec_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    rs_err_apply_if.slave  bus
);

    apply_state_e     r_state, w_state_d;
    logic             r_err_rdy, w_err_rdy_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [POS_W-1:0] r_idx, w_idx_d;
    logic             r_out_vld, w_out_vld_d;
    logic [W-1:0]     r_out_sym, w_out_sym_d;
    logic             r_out_last, w_out_last_d;
    logic [CNT_W-1:0] r_nerr, w_nerr_d;

    logic             w_err_acc, w_done_acc, w_full, w_wr_en;
    logic             w_sym_rdy, w_sym_acc, w_last;
    logic             w_clr, w_hit, w_dup;
    logic [W-1:0]     w_match_y, w_corr;
    err_entry_t       w_wr_entry;

`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    logic r_ovf, w_ovf_d;
    logic r_fail, w_fail_d;
    logic r_dec_fail, w_dec_fail_d;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{bus.nerr_exp_i, bus.err_den_zero_i, w_dup};
`endif

    assign w_err_acc  = bus.err_vld_i & r_err_rdy;
    assign w_done_acc = bus.err_done_i & r_err_rdy;
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_wr_en    = w_err_acc & ~w_full;
    assign w_wr_entry = '{pos: bus.err_pos_i, y: bus.err_y_i};

    assign w_sym_rdy  = (r_state == APPLY) & (~r_out_vld | bus.out_rdy_i);
    assign w_sym_acc  = bus.sym_vld_i & w_sym_rdy;
    assign w_last     = (r_idx == LAST_IDX);

`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    assign w_corr = (w_hit && !r_fail) ? w_match_y : '0;
`else
    assign w_corr = w_hit ? w_match_y : '0;
`endif

    rs_err_table u_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_clr       (w_clr),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (r_cnt),
        .i_wr_entry  (w_wr_entry),
        .i_match_pos (r_idx),
        .o_hit       (w_hit),
        .o_match_y   (w_match_y),
        .i_chk_pos   (bus.err_pos_i),
        .o_dup       (w_dup)
    );

    // Next-state logic for the COLLECT/APPLY FSM and all registered outputs.
    always_comb begin
        w_state_d    = r_state;
        w_err_rdy_d  = r_err_rdy;
        w_cnt_d      = r_cnt;
        w_idx_d      = r_idx;
        w_out_vld_d  = r_out_vld;
        w_out_sym_d  = r_out_sym;
        w_out_last_d = r_out_last;
        w_nerr_d     = r_nerr;
        w_clr        = 1'b0;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
        w_ovf_d      = r_ovf;
        w_fail_d     = r_fail;
        w_dec_fail_d = r_dec_fail;
`endif
        // Downstream took the pending symbol; a new accept below overrides this.
        if (r_out_vld && bus.out_rdy_i) begin
            w_out_vld_d  = 1'b0;
            w_out_last_d = 1'b0;
        end

        unique case (r_state)
            COLLECT: begin
                w_err_rdy_d = ~w_done_acc;
                if (w_wr_en) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
                if (w_err_acc) begin
                    if (w_full) begin
                        w_ovf_d = 1'b1;
                    end
                    if (bus.err_den_zero_i || (bus.err_pos_i > LAST_IDX) || w_dup) begin
                        w_fail_d = 1'b1;
                    end
                end
                // Count check uses the count including a same-cycle beat.
                if (w_done_acc) begin
                    w_fail_d = w_fail_d | w_ovf_d | (w_cnt_d != bus.nerr_exp_i);
                end
`endif
                if (w_done_acc) begin
                    w_state_d = APPLY;
                end
            end
            APPLY: begin
                w_err_rdy_d = 1'b0;
                if (w_sym_acc) begin
                    w_out_vld_d  = 1'b1;
                    w_out_sym_d  = bus.sym_i ^ w_corr;
                    w_out_last_d = w_last;
                    w_nerr_d     = w_last ? r_cnt : '0;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
                    w_dec_fail_d = w_last & r_fail;
`endif
                    w_idx_d      = r_idx + POS_W'(1);
                    if (w_last) begin
                        w_idx_d     = '0;
                        w_cnt_d     = '0;
                        w_clr       = 1'b1;
                        w_err_rdy_d = 1'b1;
                        w_state_d   = COLLECT;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
                        w_ovf_d     = 1'b0;
                        w_fail_d    = 1'b0;
`endif
                    end
                end
            end
            default: begin
                w_state_d = COLLECT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= COLLECT;
            r_err_rdy  <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_out_vld  <= 1'b0;
            r_out_sym  <= '0;
            r_out_last <= 1'b0;
            r_nerr     <= '0;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
            r_ovf      <= 1'b0;
            r_fail     <= 1'b0;
            r_dec_fail <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_err_rdy  <= w_err_rdy_d;
            r_cnt      <= w_cnt_d;
            r_idx      <= w_idx_d;
            r_out_vld  <= w_out_vld_d;
            r_out_sym  <= w_out_sym_d;
            r_out_last <= w_out_last_d;
            r_nerr     <= w_nerr_d;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
            r_ovf      <= w_ovf_d;
            r_fail     <= w_fail_d;
            r_dec_fail <= w_dec_fail_d;
`endif
        end
    end

    assign bus.err_rdy_o  = r_err_rdy;
    assign bus.sym_rdy_o  = w_sym_rdy;
    assign bus.out_vld_o  = r_out_vld;
    assign bus.out_sym_o  = r_out_sym;
    assign bus.out_last_o = r_out_last;
    assign bus.nerr_o     = r_nerr;
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    assign bus.dec_fail_o = r_dec_fail;
`else
    assign bus.dec_fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_rs_err_apply.sv
// Directed bench for rs_err_apply: error lists, fail cases, backpressure, mid-codeword reset.
module tb_rs_err_apply;
    import rs_dec_pkg::*;

`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    localparam bit FailEn = 1'b1;
`else
    localparam bit FailEn = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    rs_err_apply_if bus ();

    rs_err_apply dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [POS_W-1:0] e_pos [16];
    logic [W-1:0]     e_y   [16];
    logic             e_den [16];
    logic [W-1:0]     tx_sym  [2*N];
    logic [W-1:0]     exp_sym [2*N];
    logic [W-1:0]     rx_sym  [$];
    logic             rx_last [$];
    logic [CNT_W-1:0] rx_nerr [$];
    logic             rx_fail [$];

    task automatic clear_errs();
        for (int i = 0; i < 16; i++) begin
            e_pos[i] = '0;
            e_y[i]   = '0;
            e_den[i] = 1'b0;
        end
    endtask

    task automatic set_tx_idx(input int base);
        for (int i = 0; i < N; i++) begin
            tx_sym[base+i]  = W'(i);
            exp_sym[base+i] = W'(i);
        end
    endtask

    task automatic set_tx_zero(input int base);
        for (int i = 0; i < N; i++) begin
            tx_sym[base+i]  = '0;
            exp_sym[base+i] = '0;
        end
    endtask

    // nb==0 sends a done-only beat.
    task automatic send_errors(input int nb, input int nexp);
        int nbeats;
        int budget;
        nbeats = (nb == 0) ? 1 : nb;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk_i);
            bus.err_vld_i      = (nb != 0);
            bus.err_pos_i      = e_pos[i];
            bus.err_y_i        = e_y[i];
            bus.err_den_zero_i = e_den[i];
            bus.err_done_i     = (i == nbeats - 1);
            bus.nerr_exp_i     = CNT_W'(nexp);
            #1;
            budget = 0;
            while (!bus.err_rdy_o && budget < 200) begin
                @(negedge clk_i);
                #1;
                budget++;
            end
            if (budget >= 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL err_rdy timeout: beat %0d never accepted", i);
            end
        end
        @(negedge clk_i);
        bus.err_vld_i      = 1'b0;
        bus.err_done_i     = 1'b0;
        bus.err_den_zero_i = 1'b0;
    endtask

    task automatic sym_drive(input int start, input int count, output int stalls);
        int budget;
        stalls = 0;
        for (int i = 0; i < count; i++) begin
            @(negedge clk_i);
            bus.sym_vld_i = 1'b1;
            bus.sym_i     = tx_sym[start+i];
            #2;
            budget = 0;
            while (!bus.sym_rdy_o && budget < 100) begin
                @(negedge clk_i);
                #2;
                budget++;
                stalls++;
            end
            if (budget >= 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL sym_rdy timeout: symbol %0d never accepted", start + i);
            end
        end
        @(negedge clk_i);
        bus.sym_vld_i = 1'b0;
    endtask

    task automatic collect(input int total, input bit rnd);
        int cyc;
        cyc = 0;
        while (rx_sym.size() < total && cyc < total * 6 + 500) begin
            @(negedge clk_i);
            bus.out_rdy_i = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (bus.out_vld_o && bus.out_rdy_i) begin
                rx_sym.push_back(bus.out_sym_o);
                rx_last.push_back(bus.out_last_o);
                rx_nerr.push_back(bus.nerr_o);
                rx_fail.push_back(bus.dec_fail_o);
            end
            cyc++;
        end
        bus.out_rdy_i = 1'b1;
    endtask

    task automatic flush_rx();
        rx_sym.delete();
        rx_last.delete();
        rx_nerr.delete();
        rx_fail.delete();
    endtask

    task automatic check_cw(input int base, input int exp_nerr, input bit exp_fail,
                            input string name);
        int nbad;
        int first;
        int nlast;
        if (rx_sym.size() < base + N) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s beats: got %0d expected at least %0d", name, rx_sym.size(),
                     base + N);
        end else begin
            nbad  = 0;
            first = -1;
            nlast = 0;
            for (int i = 0; i < N; i++) begin
                if (rx_sym[base+i] !== exp_sym[base+i]) begin
                    if (first < 0) first = i;
                    nbad++;
                end
                if (rx_last[base+i] !== (i == N - 1)) nlast++;
            end
            n_checks++;
            if (nbad != 0) begin
                n_errors++;
                $display("FAIL %s symbols: %0d wrong, first idx %0d got %h expected %h", name,
                         nbad, first, rx_sym[base+first], exp_sym[base+first]);
            end
            n_checks++;
            if (nlast != 0) begin
                n_errors++;
                $display("FAIL %s out_last placement: %0d beats wrong, expected only idx %0d",
                         name, nlast, N - 1);
            end
            n_checks++;
            if (rx_nerr[base+N-1] !== CNT_W'(exp_nerr)) begin
                n_errors++;
                $display("FAIL %s nerr: got %0d expected %0d", name, rx_nerr[base+N-1],
                         exp_nerr);
            end
            n_checks++;
            if (rx_fail[base+N-1] !== exp_fail) begin
                n_errors++;
                $display("FAIL %s dec_fail: got %0b expected %0b", name, rx_fail[base+N-1],
                         exp_fail);
            end
        end
    endtask

    task automatic run_cw(input int nb, input int nexp);
        int stalls;
        flush_rx();
        send_errors(nb, nexp);
        fork
            sym_drive(0, N, stalls);
            collect(N, 1'b0);
        join
    endtask

    task automatic check_outputs_reset(input string name);
        logic [18:0] v;
        v = {bus.err_rdy_o, bus.sym_rdy_o, bus.out_vld_o, bus.out_sym_o, bus.out_last_o,
             bus.nerr_o, bus.dec_fail_o};
        n_checks++;
        if (v !== '0) begin
            n_errors++;
            $display("FAIL %s outputs {err_rdy,sym_rdy,vld,sym,last,nerr,fail}: got %h expected 0",
                     name, v);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check_outputs_reset("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_checks++;
        if (bus.err_rdy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_rdy before first edge: got %0b expected 0", bus.err_rdy_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (bus.err_rdy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL err_rdy after release: got %0b expected 1", bus.err_rdy_o);
        end
    endtask

    task automatic test_basic();
        int stalls;
        clear_errs();
        e_pos[0] = 10'd3;   e_y[0] = 10'h155;
        e_pos[1] = 10'd543; e_y[1] = 10'h001;
        set_tx_zero(0);
        exp_sym[3]   = 10'h155;
        exp_sym[543] = 10'h001;
        flush_rx();
        send_errors(2, 2);
        #1;
        n_checks++;
        if ({bus.err_rdy_o, bus.sym_rdy_o} !== 2'b01) begin
            n_errors++;
            $display("FAIL basic rdy after done: got {err_rdy,sym_rdy}=%b expected 01",
                     {bus.err_rdy_o, bus.sym_rdy_o});
        end
        fork
            sym_drive(0, N, stalls);
            collect(N, 1'b0);
        join
        n_checks++;
        if (stalls != 0) begin
            n_errors++;
            $display("FAIL basic throughput stalls: got %0d expected 0", stalls);
        end
        check_cw(0, 2, 1'b0, "basic");
    endtask

    task automatic test_empty();
        clear_errs();
        set_tx_idx(0);
        run_cw(0, 0);
        check_cw(0, 0, 1'b0, "empty");
    endtask

    task automatic test_den_zero();
        clear_errs();
        e_pos[0] = 10'd10; e_y[0] = 10'h3FF; e_den[0] = 1'b1;
        set_tx_idx(0);
        if (!FailEn) exp_sym[10] = 10'h3F5;
        run_cw(1, 1);
        check_cw(0, 1, FailEn, "den_zero");
    endtask

    task automatic test_overflow();
        clear_errs();
        set_tx_zero(0);
        for (int i = 0; i < 16; i++) begin
            e_pos[i] = POS_W'(2 * i);
            e_y[i]   = W'(i + 1);
            if (!FailEn && i < 15) exp_sym[2*i] = W'(i + 1);
        end
        run_cw(16, 15);
        check_cw(0, 15, FailEn, "overflow");
    endtask

    task automatic test_count_mismatch();
        clear_errs();
        e_pos[0] = 10'd5; e_y[0] = 10'h0AA;
        e_pos[1] = 10'd6; e_y[1] = 10'h0BB;
        set_tx_zero(0);
        if (!FailEn) begin
            exp_sym[5] = 10'h0AA;
            exp_sym[6] = 10'h0BB;
        end
        run_cw(2, 3);
        check_cw(0, 2, FailEn, "count_mismatch");
    endtask

    task automatic test_out_of_range();
        clear_errs();
        e_pos[0] = 10'd600; e_y[0] = 10'h005;
        e_pos[1] = 10'd1;   e_y[1] = 10'h007;
        set_tx_idx(0);
        if (!FailEn) exp_sym[1] = 10'h006;
        run_cw(2, 2);
        check_cw(0, 2, FailEn, "out_of_range");
    endtask

`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
    task automatic test_duplicate();
        clear_errs();
        e_pos[0] = 10'd7; e_y[0] = 10'h001;
        e_pos[1] = 10'd7; e_y[1] = 10'h002;
        set_tx_idx(0);
        run_cw(2, 2);
        check_cw(0, 2, 1'b1, "duplicate");
    endtask
`endif

    task automatic test_back_to_back();
        logic [POS_W-1:0] p1 [5];
        logic [W-1:0]     y1 [5];
        logic [POS_W-1:0] p2 [5];
        logic [W-1:0]     y2 [5];
        int stalls;
        p1 = '{10'd0, 10'd100, 10'd271, 10'd400, 10'd543};
        y1 = '{10'h001, 10'h2AA, 10'h155, 10'h3FF, 10'h010};
        p2 = '{10'd1, 10'd50, 10'd300, 10'd542, 10'd10};
        y2 = '{10'h0F0, 10'h00F, 10'h123, 10'h321, 10'h200};
        for (int i = 0; i < 2 * N; i++) begin
            tx_sym[i]  = W'($urandom_range(0, 1023));
            exp_sym[i] = tx_sym[i];
        end
        for (int k = 0; k < 5; k++) begin
            exp_sym[p1[k]]     = exp_sym[p1[k]] ^ y1[k];
            exp_sym[N + p2[k]] = exp_sym[N + p2[k]] ^ y2[k];
        end
        flush_rx();
        fork
            begin
                clear_errs();
                for (int k = 0; k < 5; k++) begin
                    e_pos[k] = p1[k];
                    e_y[k]   = y1[k];
                end
                send_errors(5, 5);
                sym_drive(0, N, stalls);
                for (int k = 0; k < 5; k++) begin
                    e_pos[k] = p2[k];
                    e_y[k]   = y2[k];
                end
                send_errors(5, 5);
                sym_drive(N, N, stalls);
            end
            collect(2 * N, 1'b1);
        join
        n_checks++;
        if (rx_sym.size() != 2 * N) begin
            n_errors++;
            $display("FAIL b2b beat count: got %0d expected %0d", rx_sym.size(), 2 * N);
        end
        check_cw(0, 5, 1'b0, "b2b_cw1");
        check_cw(N, 5, 1'b0, "b2b_cw2");
    endtask

    task automatic test_mid_reset();
        int stalls;
        clear_errs();
        e_pos[0] = 10'd20; e_y[0] = 10'h111;
        set_tx_idx(0);
        bus.out_rdy_i = 1'b1;
        send_errors(1, 1);
        sym_drive(0, 200, stalls);
        rst_ni = 1'b0;
        #1;
        check_outputs_reset("mid_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_errs();
        e_pos[0] = 10'd250; e_y[0] = 10'h0C3;
        set_tx_idx(0);
        exp_sym[250] = 10'h0FA ^ 10'h0C3;
        run_cw(1, 1);
        check_cw(0, 1, 1'b0, "after_reset");
    endtask

    initial begin
        bus.err_vld_i      = 1'b0;
        bus.err_pos_i      = '0;
        bus.err_y_i        = '0;
        bus.err_den_zero_i = 1'b0;
        bus.err_done_i     = 1'b0;
        bus.nerr_exp_i     = '0;
        bus.sym_vld_i      = 1'b0;
        bus.sym_i          = '0;
        bus.out_rdy_i      = 1'b1;

        test_reset();
        test_basic();
        test_empty();
        test_den_zero();
        test_overflow();
        test_count_mismatch();
        test_out_of_range();
`ifdef RS_ERR_APPLY_FAIL_CHECK_EN
        test_duplicate();
`endif
        test_back_to_back();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rs_err_apply.md
# rs_err_apply

Error-application stage at the tail of the Chien/Forney datapath. Consumes the per-codeword error stream (position, magnitude, zero-denominator flag) produced by the Forney stage and buffers up to T_MAX entries. Then streams the received RS(544,514) codeword symbols from the codeword buffer, XORing each stored magnitude onto its matching symbol index. Emits the corrected codeword plus per-codeword error count and decode-failure status.

## Interface
- W, 10, GF(2^10) symbol width
- POS_W, 10, symbol-index width
- N, 544, codeword length in symbols
- T_MAX, 15, error-table depth (correction capability)
- CNT_W, $clog2(T_MAX+1), error-count width
- clk_i  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low
- err_vld_i  in  1  error beat valid (from Forney stage)
- err_rdy_o  out  1  error beat ready
- err_pos_i  in  POS_W  symbol index of error, 0 = first symbol streamed
- err_y_i  in  W  error magnitude
- err_den_zero_i  in  1  Forney denominator was zero for this beat
- err_done_i  in  1  end of error list for current codeword; may coincide with the last error beat
- nerr_exp_i  in  CNT_W  expected error count (locator degree); sampled with err_done_i
- sym_vld_i  in  1  received-symbol valid
- sym_rdy_o  out  1  received-symbol ready
- sym_i  in  W  received symbol
- out_vld_o  out  1  corrected-symbol valid
- out_rdy_i  in  1  downstream ready
- out_sym_o  out  W  corrected symbol
- out_last_o  out  1  marks symbol N-1
- nerr_o  out  CNT_W  stored error count; valid while out_vld_o & out_last_o
- dec_fail_o  out  1  decode failure; valid while out_vld_o & out_last_o

## Operation
- FSM states: COLLECT, APPLY. Reset state is COLLECT.
- COLLECT:
  - err_rdy_o=1, sym_rdy_o=0.
  - Beat accepted on err_vld_i & err_rdy_o.
  - Each accepted beat writes {pos,y} to entry cnt, then cnt++.
  - Beat arriving with cnt==T_MAX is not stored and sets ovf.
  - err_done_i is honoured only while err_rdy_o=1.
  - On err_done_i, latch nerr_exp_i. A same-cycle error beat is stored first. Then go to APPLY.
- Fail flag (registered at the COLLECT->APPLY transition) is set by any of:
  - a den_zero beat
  - ovf
  - pos>=N
  - pos equal to an already-stored pos
  - final cnt != nerr_exp_i
- APPLY:
  - err_rdy_o=0, sym_rdy_o = !out_vld_o | out_rdy_i.
  - Index counter idx starts at 0.
  - On sym_vld_i & sym_rdy_o: out_sym_o <= sym_i XOR y of the valid entry with pos==idx. No XOR if fail or if no entry matches.
  - idx++ on each accepted symbol.
  - Accept at idx==N-1: out_last_o=1, nerr_o=cnt, dec_fail_o=fail. Clear idx, cnt, table valid bits, ovf and fail; return to COLLECT.
- Entries with y==0 count toward cnt; their XOR is a no-op.
- Empty list (err_done_i with cnt=0 and nerr_exp_i=0): codeword passes unmodified, dec_fail_o=0.

## Timing
- All outputs registered. Reset values:
  - err_rdy_o=0, sym_rdy_o=0, out_vld_o=0, out_sym_o=0, out_last_o=0, nerr_o=0, dec_fail_o=0.
- err_rdy_o rises the first cycle after reset release. It falls the cycle after err_done_i is accepted.
- Symbol latency: 1 cycle from accept to out_vld_o.
- Output holds stable while out_vld_o & !out_rdy_i. No symbol lost or duplicated under backpressure.
- Full throughput: 1 symbol/cycle with out_rdy_i=1. N accepts per codeword.
- Error path: 1 beat/cycle, no bubbles.
- First sym_rdy_o=1 occurs 1 cycle after the err_done_i accept cycle.
- Reset mid-codeword: table, idx and status discarded. Return to COLLECT; no partial out_last_o.

## Configuration
- RS_ERR_APPLY_FAIL_CHECK_EN defined:
  - Fail detection as above.
  - On fail, the codeword passes uncorrected and dec_fail_o reports it.
- Not defined:
  - fail logic, nerr_exp_i use and duplicate comparators removed; dec_fail_o tied 0.
  - Corrections always applied. Overflow beats still dropped.

## Structure
- Shared package rs_dec_pkg holds:
  - W, POS_W, N, T_MAX, CNT_W
  - err_entry_t {pos, y}
  - apply_state_e {COLLECT, APPLY}
- Sub-module rs_err_table:
  - T_MAX entries with valid bits, write port, clear
  - match port (idx -> hit, y)
  - duplicate-check port (incoming pos -> dup)

## Test plan
- Errors {pos 3,y 0x155},{pos 543,y 0x001}, nerr_exp 2; symbols all 0x000 -> out sym3=0x155, sym543=0x001, rest 0, nerr_o=2, dec_fail_o=0.
- Empty list, nerr_exp 0, symbols = idx[9:0] -> output identical to input, nerr_o=0.
- One beat with err_den_zero_i=1 (pos 10, y 0x3FF) -> sym10 unchanged, dec_fail_o=1. With macro off: sym10 XOR 0x3FF, dec_fail_o=0.
- 16 beats, nerr_exp 15 -> 16th dropped, nerr_o=15, dec_fail_o=1. Also: 2 beats with nerr_exp 3 -> dec_fail_o=1.
- Random out_rdy_i (50%) over two back-to-back codewords, 5 errors each -> exactly 1088 output beats, in order, corrections correct, out_last_o on beats 544 and 1088.
- rst_ni asserted at idx=200 -> all outputs return to reset values. Next full codeword with 1 error corrects normally.
